// File: rtl/relu_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : relu_maxpool2x2
// Purpose  : Optional ReLU followed by 2x2 stride-2 signed max pooling on a
//            row-major pixel stream (one pixel per in_valid, gaps allowed,
//            no backpressure). Even rows are pre-pooled horizontally into a
//            half-width row buffer; odd rows finish each window and emit it.
//            A trailing odd row (odd IMG_H) and a trailing odd column (odd
//            IMG_W) are counted but otherwise ignored.
// Config   : `define POOL_RELU_EN clamps negative pixels to zero before
//            pooling; without it the pool is a pure signed max.
// Ports    : clk        in  rising-edge clock
//            rst        in  asynchronous active-high reset
//            in_data    in  [DATA_W-1:0] signed pixel
//            in_valid   in  pixel qualifier
//            out_data   out [DATA_W-1:0] signed pooled value (held when idle)
//            out_valid  out one-cycle pulse per pooled value
//            frame_done out one-cycle pulse after the frame's last pixel
// Revision : 1.0 - initial release
// ============================================================================
module relu_maxpool2x2 #(
  parameter int DATA_W = 16,
  parameter int IMG_W  = 94,
  parameter int IMG_H  = 94,
  parameter int BUF_AW = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              frame_done
);

  localparam int CW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam bit ODD_W = (IMG_W % 2) != 0;
  localparam bit ODD_H = (IMG_H % 2) != 0;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    EMIT = 2'd1,
    SKIP = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             col_q, col_d;
  logic [RW-1:0]             row_q, row_d;
  logic signed [DATA_W-1:0]  hold_q, hold_d;
  logic [DATA_W-1:0]         out_data_q, out_data_d;
  logic                      out_valid_q, out_valid_d;
  logic                      frame_done_q, frame_done_d;

  logic signed [DATA_W-1:0]  rowbuf [0:(2**BUF_AW)-1];

  logic signed [DATA_W-1:0]  w_p;
  logic signed [DATA_W-1:0]  w_h;
  logic signed [DATA_W-1:0]  w_rd;
  logic [BUF_AW-1:0]         w_addr;
  logic                      w_buf_we;
  logic                      w_last_col;
  logic                      w_last_row;
  logic [RW-1:0]             w_row_inc;

`ifdef POOL_RELU_EN
  assign w_p = in_data[DATA_W-1] ? '0 : $signed(in_data);
`else
  assign w_p = $signed(in_data);
`endif

  // Horizontal max of the current pixel pair (valid on odd columns).
  assign w_h        = (w_p > hold_q) ? w_p : hold_q;
  assign w_addr     = BUF_AW'(col_q >> 1);
  assign w_rd       = rowbuf[w_addr];
  assign w_last_col = (col_q == CW'(IMG_W - 1));
  assign w_last_row = (row_q == RW'(IMG_H - 1));
  assign w_row_inc  = row_q + RW'(1);

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hold_d       = hold_q;
    out_data_d   = out_data_q;
    out_valid_d  = 1'b0;
    frame_done_d = 1'b0;
    w_buf_we     = 1'b0;

    if (in_valid) begin
      if (!col_q[0]) begin
        // The unpaired last column of an odd-width row must not be latched.
        if (!(ODD_W && w_last_col)) hold_d = w_p;
      end else begin
        unique case (state_q)
          FILL: w_buf_we = 1'b1;
          EMIT: begin
            out_data_d  = (w_h > w_rd) ? w_h : w_rd;
            out_valid_d = 1'b1;
          end
          default: ;
        endcase
      end

      if (w_last_col) begin
        col_d = '0;
        if (w_last_row) begin
          row_d        = '0;
          state_d      = FILL;
          frame_done_d = 1'b1;
        end else begin
          row_d = w_row_inc;
          // Next row parity decides the phase; an unpaired final row is skipped.
          if (ODD_H && (w_row_inc == RW'(IMG_H - 1))) state_d = SKIP;
          else if (row_q[0])                          state_d = FILL;
          else                                        state_d = EMIT;
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FILL;
      col_q        <= '0;
      row_q        <= '0;
      hold_q       <= '0;
      out_data_q   <= '0;
      out_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hold_q       <= hold_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Buffer contents need no reset: each entry is written on an even row
  // before the following odd row reads it.
  always_ff @(posedge clk) begin
    if (w_buf_we) rowbuf[w_addr] <= w_h;
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_relu_maxpool2x2.sv
`default_nettype none
// ============================================================================
// Module   : tb_relu_maxpool2x2
// Purpose  : Self-checking bench for relu_maxpool2x2 on a 4x4 and a 5x5
//            instance. A frame-array reference model predicts every output
//            pulse, value and frame_done cycle by cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_relu_maxpool2x2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_d4 = '0, in_d5 = '0;
  logic        in_v4 = 1'b0, in_v5 = 1'b0;
  logic [15:0] od4, od5;
  logic        ov4, ov5, fd4, fd5;

  always #5 clk = ~clk;

  relu_maxpool2x2 #(.DATA_W(16), .IMG_W(4), .IMG_H(4), .BUF_AW(2)) u4 (
    .clk(clk), .rst(rst), .in_data(in_d4), .in_valid(in_v4),
    .out_data(od4), .out_valid(ov4), .frame_done(fd4)
  );

  relu_maxpool2x2 #(.DATA_W(16), .IMG_W(5), .IMG_H(5), .BUF_AW(2)) u5 (
    .clk(clk), .rst(rst), .in_data(in_d5), .in_valid(in_v5),
    .out_data(od5), .out_valid(ov5), .frame_done(fd5)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          sel = 0;          // 0: 4x4 instance, 1: 5x5 instance
  int          mw = 4, mh = 4;
  int          mcol = 0, mrow = 0;
  int          pix [0:4][0:4];
  logic [15:0] exp_d = '0;
  int          obs_q [$];

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d (%h) expected %0d (%h)", tag,
             $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  function automatic int relu(input int x);
`ifdef POOL_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  task automatic model_reset();
    mcol = 0; mrow = 0; exp_d = '0;
  endtask

  // One clock: drive, let the edge happen, predict, then compare at +1.
  task automatic tick(input bit v, input int d, input string tag);
    bit nv, nfd;
    int pm;
    if (sel == 0) begin in_v4 = v; in_d4 = d[15:0]; in_v5 = 1'b0; end
    else          begin in_v5 = v; in_d5 = d[15:0]; in_v4 = 1'b0; end
    @(posedge clk);
    nv = 1'b0; nfd = 1'b0;
    if (v && !rst) begin
      pix[mrow][mcol] = relu(d);
      // A window completes on its bottom-right pixel; trailing odd row/col never qualify.
      if ((mrow % 2 == 1) && (mcol % 2 == 1)) begin
        pm = max2(max2(pix[mrow-1][mcol-1], pix[mrow-1][mcol]),
                  max2(pix[mrow][mcol-1],   pix[mrow][mcol]));
        exp_d = pm[15:0];
        nv = 1'b1;
      end
      nfd = (mrow == mh - 1) && (mcol == mw - 1);
      mcol++;
      if (mcol == mw) begin
        mcol = 0; mrow++;
        if (mrow == mh) mrow = 0;
      end
    end
    #1;
    if (sel == 0) begin
      check({tag, ".valid"}, {15'd0, ov4}, {15'd0, nv});
      check({tag, ".done"},  {15'd0, fd4}, {15'd0, nfd});
      check({tag, ".data"},  od4, exp_d);
      if (ov4 === 1'b1) obs_q.push_back(int'($signed(od4)));
    end else begin
      check({tag, ".valid"}, {15'd0, ov5}, {15'd0, nv});
      check({tag, ".done"},  {15'd0, fd5}, {15'd0, nfd});
      check({tag, ".data"},  od5, exp_d);
      if (ov5 === 1'b1) obs_q.push_back(int'($signed(od5)));
    end
  endtask

  task automatic do_reset(input int cycles, input string tag);
    rst = 1'b1;
    in_v4 = 1'b0; in_v5 = 1'b0;
    model_reset();
    for (int i = 0; i < cycles; i++) tick(1'b0, 0, tag);
    rst = 1'b0;
  endtask

  // Feed pixels base..base+n-1, optionally with random idle gaps.
  task automatic feed_seq(input int base, input int n, input bit gaps, input string tag);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        int g = int'($urandom_range(0, 2));
        for (int k = 0; k < g; k++) tick(1'b0, 0, tag);
      end
      tick(1'b1, base + i, tag);
    end
  endtask

  task automatic feed_rand(input int n, input string tag);
    logic [15:0] r;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 3) == 0) tick(1'b0, 0, tag);
      r = 16'($urandom);
      tick(1'b1, int'($signed(r)), tag);
    end
  endtask

  task automatic check_obs(input string tag, input int e0, input int e1, input int e2, input int e3);
    int exp_v [4];
    exp_v = '{e0, e1, e2, e3};
    check({tag, ".count"}, 16'(obs_q.size()), 16'd4);
    for (int i = 0; i < 4; i++)
      if (i < obs_q.size()) check($sformatf("%s.out%0d", tag, i), 16'(obs_q[i]), 16'(exp_v[i]));
  endtask

  initial begin
    // Reset state of both instances
    sel = 0; mw = 4; mh = 4;
    do_reset(2, "reset");
    check("reset.od5", od5, 16'd0);
    check("reset.ov5", {15'd0, ov5}, 16'd0);

    // 4x4 ramp 1..16 contiguous
    obs_q.delete();
    feed_seq(1, 16, 1'b0, "ramp4");
    check_obs("ramp4", 6, 8, 14, 16);

    // 4x4 all -5
    obs_q.delete();
    for (int i = 0; i < 16; i++) tick(1'b1, -5, "neg4");
`ifdef POOL_RELU_EN
    check_obs("neg4", 0, 0, 0, 0);
`else
    check_obs("neg4", -5, -5, -5, -5);
`endif

    // 4x4 ramp with random gaps; latency checked every cycle by tick
    obs_q.delete();
    feed_seq(1, 16, 1'b1, "gap4");
    check_obs("gap4", 6, 8, 14, 16);

    // Reset mid-frame after 7 pixels, then a clean frame
    feed_seq(100, 7, 1'b0, "part4");
    do_reset(2, "midrst");
    tick(1'b0, 0, "postrst");
    obs_q.delete();
    feed_seq(1, 16, 1'b0, "after4");
    check_obs("after4", 6, 8, 14, 16);

    // Back-to-back frames 1..16, 17..32
    obs_q.delete();
    feed_seq(1, 32, 1'b0, "b2b4");
    check("b2b4.count", 16'(obs_q.size()), 16'd8);
    if (obs_q.size() == 8) begin
      check("b2b4.out4", 16'(obs_q[4]), 16'd22);
      check("b2b4.out7", 16'(obs_q[7]), 16'd32);
    end

    // Random signed data, three frames with gaps
    feed_rand(48, "rand4");
    for (int i = 0; i < 3; i++) tick(1'b0, 0, "idle4");

    // 5x5 instance: odd width and height
    sel = 1; mw = 5; mh = 5;
    do_reset(2, "reset5");
    obs_q.delete();
    feed_seq(1, 25, 1'b0, "ramp5");
    check_obs("ramp5", 7, 9, 17, 19);
    obs_q.delete();
    feed_seq(1, 25, 1'b1, "gap5");
    check_obs("gap5", 7, 9, 17, 19);
    feed_rand(75, "rand5");
    for (int i = 0; i < 3; i++) tick(1'b0, 0, "idle5");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
